// File: rtl/bsg_sync_sync_filter_pkg.sv
// Shared constants and helpers for the synchronise-and-debounce filter.
package bsg_sync_sync_filter_pkg;

  // Fewest flops that still give a metastability-safe synchroniser.
  localparam int unsigned min_stages_c        = 2;
  // Fewest edges of disagreement before a new level is accepted.
  localparam int unsigned min_filter_cycles_c = 1;

  // Width of a counter that must hold values 0 .. filter_cycles-1.
  function automatic int unsigned cnt_width_f(input int unsigned filter_cycles);
    return $clog2(filter_cycles + 1);
  endfunction

endpackage

// File: rtl/bsg_sync_filter_chan.sv
// One channel: synchroniser chain, debounce counter and edge pulses.
module bsg_sync_filter_chan
  import bsg_sync_sync_filter_pkg::*;
#(
  parameter int   stages_p        = 2,
  parameter int   filter_cycles_p = 1,
  parameter logic reset_val_p     = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic sync_o,
  output logic filt_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned cnt_width_lp = cnt_width_f(filter_cycles_p);
  localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(filter_cycles_p - 1);

  // Marked so place-and-route keeps these flops adjacent and never retimes or merges them.
  (* ASYNC_REG = "TRUE", dont_touch = "true", keep = "true" *)
  logic [stages_p-1:0] sync_chain_reg;

  logic [cnt_width_lp-1:0] cnt_reg;
  logic                    filt_reg;
  logic                    rise_reg;
  logic                    fall_reg;
  logic                    sync;

  assign sync = sync_chain_reg[stages_p-1];

  // Shift the raw input through the synchroniser chain.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_chain_reg <= {stages_p{reset_val_p}};
    end else begin
      sync_chain_reg <= {sync_chain_reg[stages_p-2:0], async_i};
    end
  end

  // Accept a new level only after filter_cycles_p consecutive disagreeing edges;
  // any agreeing edge throws away the partial count.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      filt_reg <= reset_val_p;
      cnt_reg  <= '0;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
      if (sync != filt_reg) begin
        if (cnt_reg == last_cnt_lp) begin
          filt_reg <= sync;
          cnt_reg  <= '0;
          rise_reg <= sync;
          fall_reg <= ~sync;
        end else begin
          cnt_reg <= cnt_reg + cnt_width_lp'(1);
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign sync_o = sync;
  assign filt_o = filt_reg;
  assign rise_o = rise_reg;
  assign fall_o = fall_reg;

endmodule

// File: rtl/bsg_sync_sync_filter.sv
// Multi-channel synchroniser with per-channel debounce and edge pulses.
module bsg_sync_sync_filter
  import bsg_sync_sync_filter_pkg::*;
#(
  parameter int                 width_p         = 1,
  parameter int                 stages_p        = 2,
  parameter int                 filter_cycles_p = 1,
  parameter logic [width_p-1:0] reset_val_p     = '0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] async_data_i,
  output logic [width_p-1:0] sync_data_o,
  output logic [width_p-1:0] filt_data_o,
  output logic [width_p-1:0] rise_o,
  output logic [width_p-1:0] fall_o
);

  // Reject parameter sets the channel logic cannot implement.
  if (width_p < 1) begin : g_bad_width
    $error("bsg_sync_sync_filter: width_p must be at least 1");
  end
  if (stages_p < int'(min_stages_c)) begin : g_bad_stages
    $error("bsg_sync_sync_filter: stages_p below minimum synchroniser depth");
  end
  if (filter_cycles_p < int'(min_filter_cycles_c)) begin : g_bad_filter
    $error("bsg_sync_sync_filter: filter_cycles_p below minimum");
  end

  // Channels are fully independent copies.
  for (genvar gi = 0; gi < width_p; gi++) begin : g_chan
    bsg_sync_filter_chan #(
      .stages_p       (stages_p),
      .filter_cycles_p(filter_cycles_p),
      .reset_val_p    (reset_val_p[gi])
    ) u_chan (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .async_i(async_data_i[gi]),
      .sync_o (sync_data_o[gi]),
      .filt_o (filt_data_o[gi]),
      .rise_o (rise_o[gi]),
      .fall_o (fall_o[gi])
    );
  end

endmodule

// File: tb/tb_bsg_sync_sync_filter.sv
// Scoreboard bench for bsg_sync_sync_filter: a main 4-channel instance
// (stages 2, filter 3, reset 0) and a second one (stages 3, filter 1, reset 1111).
module tb_bsg_sync_sync_filter;

  logic       clk;
  logic       rst;
  logic [3:0] in1;
  logic [3:0] in2;
  logic [3:0] sync1, filt1, rise1, fall1;
  logic [3:0] sync2, filt2, rise2, fall2;

  int checks;
  int errors;
  int edge_cnt;
  int base_edge;

  typedef struct {
    int         edge_no;
    int         sel;
    logic [3:0] val;
  } exp_t;

  exp_t sb_q[$];

  bsg_sync_sync_filter #(
    .width_p(4), .stages_p(2), .filter_cycles_p(3), .reset_val_p(4'b0000)
  ) dut (
    .clk_i(clk), .reset_i(rst), .async_data_i(in1),
    .sync_data_o(sync1), .filt_data_o(filt1), .rise_o(rise1), .fall_o(fall1)
  );

  bsg_sync_sync_filter #(
    .width_p(4), .stages_p(3), .filter_cycles_p(1), .reset_val_p(4'b1111)
  ) dut2 (
    .clk_i(clk), .reset_i(rst), .async_data_i(in2),
    .sync_data_o(sync2), .filt_data_o(filt2), .rise_o(rise2), .fall_o(fall2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] observe(input int sel);
    case (sel)
      0: return sync1;
      1: return filt1;
      2: return rise1;
      3: return fall1;
      4: return sync2;
      5: return filt2;
      6: return rise2;
      default: return fall2;
    endcase
  endfunction

  function automatic string sel_name(input int sel);
    case (sel)
      0: return "sync";
      1: return "filt";
      2: return "rise";
      3: return "fall";
      4: return "sync2";
      5: return "filt2";
      6: return "rise2";
      default: return "fall2";
    endcase
  endfunction

  task automatic push_exp(input int rel, input int sel, input logic [3:0] val);
    exp_t e;
    e.edge_no = base_edge + rel;
    e.sel     = sel;
    e.val     = val;
    sb_q.push_back(e);
  endtask

  task automatic exp1(input int k, input logic [3:0] s, input logic [3:0] f,
                      input logic [3:0] r, input logic [3:0] fa);
    push_exp(k, 0, s);
    push_exp(k, 1, f);
    push_exp(k, 2, r);
    push_exp(k, 3, fa);
  endtask

  task automatic exp2(input int k, input logic [3:0] s, input logic [3:0] f,
                      input logic [3:0] r, input logic [3:0] fa);
    push_exp(k, 4, s);
    push_exp(k, 5, f);
    push_exp(k, 6, r);
    push_exp(k, 7, fa);
  endtask

  // One clock edge, then compare every scoreboard entry due at this edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    edge_cnt++;
    while (sb_q.size() > 0 && sb_q[0].edge_no <= edge_cnt) begin
      e = sb_q.pop_front();
      chk($sformatf("%s@e%0d", sel_name(e.sel), e.edge_no - base_edge),
          32'(observe(e.sel)), 32'(e.val));
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Apply a full step on the main instance and expect the standard latency.
  task automatic step_main(input logic [3:0] old_v, input logic [3:0] new_v, input int n);
    in1 = new_v;
    base_edge = edge_cnt;
    for (int k = 1; k <= n; k++) begin
      exp1(k, (k >= 2) ? new_v : old_v,
              (k >= 5) ? new_v : old_v,
              (k == 5) ? (new_v & ~old_v) : 4'b0000,
              (k == 5) ? (old_v & ~new_v) : 4'b0000);
    end
    ticks(n);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    edge_cnt = 0;
    base_edge = 0;
    rst = 1'b1;
    in1 = 4'b0000;
    in2 = 4'b0000;

    // Reset state with inputs low, then a held-off input change during reset.
    ticks(2);
    chk("rst_sync", 32'(sync1), 32'h0);
    chk("rst_filt", 32'(filt1), 32'h0);
    chk("rst_rise", 32'(rise1), 32'h0);
    chk("rst_fall", 32'(fall1), 32'h0);
    chk("rst_sync2", 32'(sync2), 32'hf);
    chk("rst_filt2", 32'(filt2), 32'hf);
    in1 = 4'b1000;
    ticks(2);
    chk("rst_hold_sync", 32'(sync1), 32'h0);
    chk("rst_hold_filt", 32'(filt1), 32'h0);
    chk("rst_hold_rise", 32'(rise1), 32'h0);
    in1 = 4'b0000;

    // Release reset; channel 0 rises, and the second instance falls from its reset level.
    rst = 1'b0;
    in1 = 4'b0001;
    base_edge = edge_cnt;
    for (int k = 1; k <= 7; k++) begin
      exp1(k, (k >= 2) ? 4'b0001 : 4'b0000, (k >= 5) ? 4'b0001 : 4'b0000,
              (k == 5) ? 4'b0001 : 4'b0000, 4'b0000);
      exp2(k, (k >= 3) ? 4'b0000 : 4'b1111, (k >= 4) ? 4'b0000 : 4'b1111,
              4'b0000, (k == 4) ? 4'b1111 : 4'b0000);
    end
    ticks(7);

    // Channel 0 back low, then a glitch too short to be accepted.
    step_main(4'b0001, 4'b0000, 6);
    in1 = 4'b0001;
    base_edge = edge_cnt;
    for (int k = 1; k <= 8; k++) begin
      exp1(k, (k == 2 || k == 3) ? 4'b0001 : 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    end
    ticks(2);
    in1 = 4'b0000;
    ticks(6);
    // A genuine change afterwards must take the full latency (count was cleared).
    step_main(4'b0000, 4'b0001, 7);

    // Settle channel 2 high, then simultaneous rise on 1 and fall on 2.
    step_main(4'b0001, 4'b0101, 6);
    step_main(4'b0101, 4'b0011, 6);

    // Drop channel 0, then reset mid-count on its rise.
    step_main(4'b0011, 4'b0010, 6);
    in1 = 4'b0011;
    base_edge = edge_cnt;
    for (int k = 1; k <= 4; k++) begin
      exp1(k, (k >= 2) ? 4'b0011 : 4'b0010, 4'b0010, 4'b0000, 4'b0000);
    end
    ticks(4);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_filt", 32'(filt1), 32'h0);
    chk("async_rst_sync", 32'(sync1), 32'h0);
    chk("async_rst_rise", 32'(rise1), 32'h0);
    chk("async_rst_fall", 32'(fall1), 32'h0);
    tick();
    chk("held_rst_filt", 32'(filt1), 32'h0);
    chk("held_rst_rise", 32'(rise1), 32'h0);
    rst = 1'b0;
    step_main(4'b0000, 4'b0011, 7);

    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
